event_encoder_16_to_4: RTL and testbench

//  Inverse of the 4-to-16 one-hot decode path. Collects single-cycle event pulses on
//  16 one-hot lines into a pending register. Encodes them one at a time into a 4-bit

---
 rtl/event_encoder_16_to_4_if.sv | 49 ++++
 rtl/event_encoder_16_to_4.sv | 152 +++++++++++++++
 tb/tb_event_encoder_16_to_4.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/event_encoder_16_to_4_if.sv
`default_nettype none
// ============================================================================
// Module      : event_encoder_16_to_4_if
// Description : Bundle of the event-capture inputs, the indexed-event
//               valid/ready output and the status outputs of
//               event_encoder_16_to_4.
//   ena        event capture enable
//   in         N one-hot event pulse lines
//   out        W-bit index of the presented event
//   out_valid  out holds a pending event
//   out_ready  consumer accepts out when out_valid && out_ready
//   pending    registered pending-event vector
//   overflow   one-cycle pulse on an event hitting an already-pending bit
//   Modport slave is the encoder side; master is the source/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface event_encoder_16_to_4_if #(
   parameter int N = 16,
   parameter int W = 4
);
   logic         ena;
   logic [N-1:0] in;
   logic [W-1:0] out;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] pending;
   logic         overflow;

   modport slave (
      input  ena,
      input  in,
      input  out_ready,
      output out,
      output out_valid,
      output pending,
      output overflow
   );

   modport master (
      output ena,
      output in,
      output out_ready,
      input  out,
      input  out_valid,
      input  pending,
      input  overflow
   );
endinterface
`default_nettype wire

// File: rtl/event_encoder_16_to_4.sv
`default_nettype none
// ============================================================================
// Module      : event_encoder_16_to_4
// Description : Collects single-cycle event pulses on N one-hot lines into a
//               pending register and presents them one at a time as a W-bit
//               index on a valid/ready handshake. Selection is round-robin
//               from a rotating pointer (ROUND_ROBIN=1) or lowest index first
//               (ROUND_ROBIN=0). Back-to-back delivery gives one event per
//               cycle while the consumer stays ready.
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset
//   bus        event_encoder_16_to_4_if.slave
//              (ena, in, out_ready in; out, out_valid, pending, overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module event_encoder_16_to_4 #(
   parameter int N           = 16,
   parameter int W           = 4,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  wire logic                clk,
   input  wire logic                rst,
   event_encoder_16_to_4_if.slave   bus
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t       r_state;
   state_t       w_state_next;
   logic [W-1:0] r_out;
   logic [W-1:0] w_out_next;
   logic         r_valid;
   logic         w_valid_next;
   logic [N-1:0] r_pending;
   logic         r_overflow;

   logic         w_acc;
   logic [N-1:0] w_clr;
   logic [N-1:0] w_set;
   logic [N-1:0] w_remain;
   logic         w_any;
   logic [W-1:0] w_start;
   logic [W-1:0] w_sel;

   assign w_acc    = r_valid & bus.out_ready;
   assign w_clr    = w_acc ? (N'(1) << r_out) : '0;
   assign w_set    = bus.ena ? bus.in : '0;
   // The bit being accepted is excluded, so the next pick never repeats it
   // unless it was re-set in this same cycle (it then lands in r_pending).
   assign w_remain = r_pending & ~w_clr;
   assign w_any    = |w_remain;

   // ------------------------------------------------------------------------
   // Search start point: rotating pointer or fixed zero
   // ------------------------------------------------------------------------
   generate
      if (ROUND_ROBIN) begin : g_rr
         logic [W-1:0] r_ptr;

         // Pointer moves just past the index being accepted.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_ptr <= '0;
            end else if (w_acc) begin
               r_ptr <= r_out + W'(1);
            end
         end

         assign w_start = r_ptr;
      end else begin : g_fixed
         assign w_start = '0;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Selection: first set bit at w_start, w_start+1, ... modulo N. N is a
   // power of two, so W-bit addition wraps naturally. Scanning from the far
   // end lets the last hit (closest to w_start) win without a found flag.
   // ------------------------------------------------------------------------
   always_comb begin
      w_sel = w_start;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_remain[w_start + W'(i)]) begin
            w_sel = w_start + W'(i);
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state / output register loads
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_out_next   = r_out;
      w_valid_next = r_valid;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_out_next   = w_sel;
               w_valid_next = 1'b1;
               w_state_next = PRESENT;
            end
         end
         PRESENT: begin
            // Without an accept, out is held even if a higher-priority event
            // arrives; presented events are never preempted.
            if (w_acc) begin
               if (w_any) begin
                  w_out_next = w_sel;
               end else begin
                  w_valid_next = 1'b0;
                  w_state_next = IDLE;
               end
            end
         end
         default: begin
            w_valid_next = 1'b0;
            w_state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, output and pending registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_out      <= '0;
         r_valid    <= 1'b0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_out      <= w_out_next;
         r_valid    <= w_valid_next;
         // A set on a bit being cleared is a fresh event, not an overflow.
         r_pending  <= w_remain | w_set;
         r_overflow <= |(w_set & w_remain);
      end
   end

   assign bus.out       = r_out;
   assign bus.out_valid = r_valid;
   assign bus.pending   = r_pending;
   assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder_16_to_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_encoder_16_to_4
// Description : Directed bench for event_encoder_16_to_4. One round-robin and
//               one fixed-priority instance share clk/rst. Inputs change and
//               outputs are sampled 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_encoder_16_to_4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   event_encoder_16_to_4_if #(.N(16), .W(4)) u_if_rr ();
   event_encoder_16_to_4_if #(.N(16), .W(4)) u_if_fp ();

   event_encoder_16_to_4 #(.N(16), .W(4), .ROUND_ROBIN(1'b1)) u_dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (u_if_rr.slave)
   );

   event_encoder_16_to_4 #(.N(16), .W(4), .ROUND_ROBIN(1'b0)) u_dut_fp (
      .clk (clk),
      .rst (rst),
      .bus (u_if_fp.slave)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Presented-event check on the round-robin instance
   task automatic check_rr(input string tag, input logic valid, input logic [3:0] idx);
      check_value({tag, ".valid"}, 32'(u_if_rr.out_valid), 32'(valid));
      if (valid) check_value({tag, ".out"}, 32'(u_if_rr.out), 32'(idx));
   endtask

   task automatic check_fp(input string tag, input logic valid, input logic [3:0] idx);
      check_value({tag, ".valid"}, 32'(u_if_fp.out_valid), 32'(valid));
      if (valid) check_value({tag, ".out"}, 32'(u_if_fp.out), 32'(idx));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- 1. reset with all lines firing ----------------
      u_if_rr.ena = 1'b1; u_if_rr.in = 16'hFFFF; u_if_rr.out_ready = 1'b0;
      u_if_fp.ena = 1'b1; u_if_fp.in = 16'hFFFF; u_if_fp.out_ready = 1'b0;
      do_reset();
      u_if_rr.in = 16'h0000;
      u_if_fp.in = 16'h0000;
      u_if_fp.ena = 1'b0;
      check_value("rst.pending", 32'(u_if_rr.pending), 32'h0);
      check_value("rst.valid", 32'(u_if_rr.out_valid), 32'h0);
      check_value("rst.overflow", 32'(u_if_rr.overflow), 32'h0);
      check_value("rst.out", 32'(u_if_rr.out), 32'h0);
      check_value("rst.fp_pending", 32'(u_if_fp.pending), 32'h0);
      tick();
      check_value("rst.valid_after", 32'(u_if_rr.out_valid), 32'h0);
      check_value("rst.pending_after", 32'(u_if_rr.pending), 32'h0);

      // ---------------- 2. single event on line 5 ----------------
      u_if_rr.out_ready = 1'b1;
      u_if_rr.in = 16'h0020;
      tick();
      u_if_rr.in = 16'h0000;
      check_value("single.pending_set", 32'(u_if_rr.pending), 32'h0020);
      check_rr("single.latency", 1'b0, 4'd0);
      tick();
      check_rr("single.present", 1'b1, 4'd5);
      tick();
      check_rr("single.gone", 1'b0, 4'd0);
      check_value("single.out_kept", 32'(u_if_rr.out), 32'd5);
      check_value("single.pending_clr", 32'(u_if_rr.pending), 32'h0);

      // ---------------- 3. round-robin drain and wrap ----------------
      do_reset();
      u_if_rr.in = 16'h8101;
      tick();
      u_if_rr.in = 16'h0000;
      tick();
      check_rr("rr.first", 1'b1, 4'd0);
      tick();
      check_rr("rr.second", 1'b1, 4'd8);
      tick();
      check_rr("rr.third", 1'b1, 4'd15);
      tick();
      check_rr("rr.drained", 1'b0, 4'd0);
      check_value("rr.pending_empty", 32'(u_if_rr.pending), 32'h0);
      // Pointer wrapped 15 -> 0, so line 0 is found before line 8.
      u_if_rr.in = 16'h0101;
      tick();
      u_if_rr.in = 16'h0000;
      tick();
      check_rr("rr.wrap_first", 1'b1, 4'd0);
      tick();
      check_rr("rr.wrap_second", 1'b1, 4'd8);
      tick();
      check_rr("rr.wrap_done", 1'b0, 4'd0);

      // ---------------- 4. backpressure ----------------
      do_reset();
      u_if_rr.out_ready = 1'b0;
      u_if_rr.in = 16'h0006;
      tick();
      u_if_rr.in = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_rr("bp.hold", 1'b1, 4'd1);
      end
      check_value("bp.pending", 32'(u_if_rr.pending), 32'h0006);
      u_if_rr.out_ready = 1'b1;
      tick();
      check_rr("bp.next", 1'b1, 4'd2);
      tick();
      check_rr("bp.done", 1'b0, 4'd0);

      // ---------------- 5. overflow / merge / re-set in accept ----------------
      do_reset();
      u_if_rr.out_ready = 1'b0;
      u_if_rr.in = 16'h0010;
      tick();
      check_value("ovf.first_none", 32'(u_if_rr.overflow), 32'h0);
      tick();
      u_if_rr.in = 16'h0000;
      check_value("ovf.pulse", 32'(u_if_rr.overflow), 32'h1);
      tick();
      check_value("ovf.pulse_end", 32'(u_if_rr.overflow), 32'h0);
      check_rr("ovf.merged", 1'b1, 4'd4);
      check_value("ovf.pending_one", 32'(u_if_rr.pending), 32'h0010);
      u_if_rr.out_ready = 1'b1;
      tick();
      check_rr("ovf.delivered_once", 1'b0, 4'd0);
      tick();
      check_rr("ovf.no_repeat", 1'b0, 4'd0);
      u_if_rr.in = 16'h0010;
      tick();
      u_if_rr.in = 16'h0000;
      tick();
      check_rr("reset_in_acc.present", 1'b1, 4'd4);
      u_if_rr.in = 16'h0010;
      tick();
      u_if_rr.in = 16'h0000;
      check_value("reset_in_acc.no_ovf", 32'(u_if_rr.overflow), 32'h0);
      check_value("reset_in_acc.pending", 32'(u_if_rr.pending), 32'h0010);
      check_rr("reset_in_acc.gap", 1'b0, 4'd0);
      tick();
      check_rr("reset_in_acc.again", 1'b1, 4'd4);
      tick();
      check_rr("reset_in_acc.done", 1'b0, 4'd0);
      check_value("reset_in_acc.empty", 32'(u_if_rr.pending), 32'h0);

      // ---------------- reset mid-drain ----------------
      do_reset();
      u_if_rr.in = 16'h00F0;
      tick();
      u_if_rr.in = 16'h0000;
      tick();
      check_rr("middrain.first", 1'b1, 4'd4);
      tick();
      check_rr("middrain.second", 1'b1, 4'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_value("middrain.pending", 32'(u_if_rr.pending), 32'h0);
      check_rr("middrain.valid", 1'b0, 4'd0);
      tick();
      check_rr("middrain.stays_idle", 1'b0, 4'd0);

      // ---------------- 6. fixed priority with ena gating ----------------
      do_reset();
      u_if_fp.out_ready = 1'b1;
      u_if_fp.ena = 1'b0;
      u_if_fp.in = 16'h0081;
      tick();
      u_if_fp.in = 16'h0000;
      tick();
      check_value("fp.gated_pending", 32'(u_if_fp.pending), 32'h0);
      check_fp("fp.gated_valid", 1'b0, 4'd0);
      u_if_fp.ena = 1'b1;
      u_if_fp.in = 16'h0081;
      tick();
      u_if_fp.in = 16'h0000;
      tick();
      check_fp("fp.first", 1'b1, 4'd0);
      tick();
      check_fp("fp.second", 1'b1, 4'd7);
      tick();
      check_fp("fp.done", 1'b0, 4'd0);
      // After delivering 8 a rotating pointer would favour 9; fixed picks 0.
      u_if_fp.in = 16'h0104;
      tick();
      u_if_fp.in = 16'h0000;
      tick();
      check_fp("fp.a", 1'b1, 4'd2);
      tick();
      check_fp("fp.b", 1'b1, 4'd8);
      tick();
      u_if_fp.in = 16'h0201;
      tick();
      u_if_fp.in = 16'h0000;
      tick();
      check_fp("fp.lowest_first", 1'b1, 4'd0);
      tick();
      check_fp("fp.then_nine", 1'b1, 4'd9);
      tick();
      check_fp("fp.empty", 1'b0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
